autobaud_ctrl: RTL and testbench

- Calibrates the UART baud rate from an incoming 0x55 sync character, then programs the divisor of the shared baud_generator (tick every dvsr+1 clocks, 16x oversampling).
- Measures 8 bit times on the rx line and computes a rounded divisor.
- Commits the new divisor on a baud tick so the generator counter never wraps past a smaller new divisor.
- Sits beside baud_generator in the UART top; its dvsr output drives the generator's dvsr input directly.

---
 rtl/autobaud_ctrl_pkg.sv | 19 +
 rtl/autobaud_ctrl_rx_sync_edge.sv | 28 ++
 rtl/autobaud_ctrl.sv | 130 +++++++++++++
 tb/tb_autobaud_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/autobaud_ctrl_pkg.sv
// Shared UART constants and the autobaud calibration state encoding.
package autobaud_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_START,
    MEASURE,
    COMMIT
  } state_t;

  // 8 bit times x 16x oversampling -> divide the measured span by 128
  localparam int MEAS_SHIFT = 7;
  localparam int ROUND_ADD  = 64;

  localparam logic [1:0]  EDGE_TARGET  = 2'd3;
  localparam logic [15:0] DEFAULT_DVSR = 16'd650;

endpackage

// File: rtl/autobaud_ctrl_rx_sync_edge.sv
// Two-flop synchronizer for an asynchronous serial line plus a falling-edge pulse.
module rx_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic sync1;
  logic rx_s_prev;

  // Reset to the idle-high level so leaving reset never looks like a start edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      rx_s_prev <= 1'b1;
    end else begin
      sync1     <= rx;
      rx_s      <= sync1;
      rx_s_prev <= rx_s;
    end
  end

  assign fall = rx_s_prev & ~rx_s;

endmodule

// File: rtl/autobaud_ctrl.sv
// Measures a 0x55 sync character on rx and programs the baud generator divisor,
// switching the divisor only on a baud tick so the generator counter never overruns it.
module autobaud_ctrl #(
  parameter int              BITS         = 16,
  parameter int              CNT_BITS     = BITS + 7,
  parameter logic [BITS-1:0] DEFAULT_DVSR = BITS'(autobaud_ctrl_pkg::DEFAULT_DVSR)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic            rx,
  input  logic            baud_tick,
  output logic [BITS-1:0] dvsr,
  output logic            busy,
  output logic            done,
  output logic            error
);

  import autobaud_ctrl_pkg::*;

  state_t              state;
  state_t              state_next;
  logic                rx_s;
  logic                fall;
  logic [CNT_BITS-1:0] cnt;
  logic [1:0]          edges;
  logic [BITS-1:0]     cand;
  logic [CNT_BITS:0]   q;
  logic                load_cnt;
  logic                inc_edge;
  logic                capture;
  logic                commit_fire;
  logic                err_fire;

  rx_sync_edge u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .rx_s    (rx_s),
    .fall    (fall)
  );

  // Rounded divisor candidate; one spare bit keeps the rounding add from overflowing
  assign q    = ({1'b0, cnt} + (CNT_BITS+1)'(ROUND_ADD)) >> MEAS_SHIFT;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    load_cnt    = 1'b0;
    inc_edge    = 1'b0;
    capture     = 1'b0;
    commit_fire = 1'b0;
    err_fire    = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) state_next = ARM;
        end
        ARM: begin
          if (rx_s) state_next = WAIT_START;
        end
        WAIT_START: begin
          if (fall) begin
            load_cnt   = 1'b1;
            state_next = MEASURE;
          end
        end
        MEASURE: begin
          if (fall && (edges == EDGE_TARGET)) begin
            if (q < (CNT_BITS+1)'(2)) begin
              err_fire   = 1'b1;
              state_next = IDLE;
            end else begin
              capture    = 1'b1;
              state_next = COMMIT;
            end
          end else if (&cnt) begin
            err_fire   = 1'b1;
            state_next = IDLE;
          end else if (fall) begin
            inc_edge = 1'b1;
          end
        end
        COMMIT: begin
          if (baud_tick) begin
            commit_fire = 1'b1;
            state_next  = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // The generator clears its count on the same tick edge that loads the new divisor
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      edges <= '0;
      cand  <= '0;
      dvsr  <= DEFAULT_DVSR;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      done  <= commit_fire;
      error <= err_fire;
      if (load_cnt) begin
        cnt   <= CNT_BITS'(1);
        edges <= '0;
      end else if (state == MEASURE) begin
        cnt <= cnt + CNT_BITS'(1);
        if (inc_edge) edges <= edges + 2'd1;
      end
      if (capture) cand <= BITS'(q - (CNT_BITS+1)'(1));
      if (commit_fire) dvsr <= cand;
    end
  end

endmodule

// File: tb/tb_autobaud_ctrl.sv
// Directed bench for autobaud_ctrl with a behavioural baud generator driven by dvsr.
module tb_autobaud_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rx = 1'b1;
  logic        baud_tick;
  logic [15:0] dvsr;
  logic        busy;
  logic        done;
  logic        error;

  logic [15:0] gen_cnt;
  logic        tick_en = 1'b1;
  logic        tick_last = 1'b0;
  logic        done_tick_ok = 1'b0;
  logic [15:0] done_dvsr = '0;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int error_cnt = 0;
  int overlap_cnt = 0;

  always #5 clk = ~clk;

  autobaud_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .rx        (rx),
    .baud_tick (baud_tick),
    .dvsr      (dvsr),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // Baud generator model: counts 0..dvsr and ticks on the terminal count
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) gen_cnt <= '0;
    else if (gen_cnt == dvsr) gen_cnt <= '0;
    else gen_cnt <= gen_cnt + 16'd1;
  end

  assign baud_tick = tick_en && (gen_cnt == dvsr);

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_dvsr = dvsr;
      done_tick_ok = tick_last;
    end
    if (error) error_cnt++;
    if (done && error) overlap_cnt++;
    tick_last = baud_tick;
  end

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step_n(1);
    start = 1'b0;
  endtask

  // Falls are 2*p cycles apart, so five falls span exactly 8*p cycles
  task automatic send_sync(input int p, input int nfalls);
    for (int k = 0; k < nfalls; k++) begin
      rx = 1'b0;
      if (k == nfalls - 1) break;
      step_n(p);
      rx = 1'b1;
      step_n(p);
    end
  endtask

  task automatic wait_result(input string name, input int bound, output bit got_done, output bit got_error);
    got_done = 1'b0;
    got_error = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done || error) begin
        got_done = done;
        got_error = error;
        return;
      end
    end
    tests++;
    fails++;
    $display("[TB] FAIL %s timeout: no done/error within %0d cycles", name, bound);
  endtask

  task automatic run_cal(input string name, input int p, input int hold,
                         input logic [15:0] exp_dvsr, input bit exp_err);
    bit gd;
    bit ge;
    int first;
    int gap;
    done_cnt = 0;
    error_cnt = 0;
    overlap_cnt = 0;
    if (hold > 0) begin
      rx = 1'b0;
      step_n(4);
    end
    pulse_start();
    if (hold > 0) begin
      step_n(hold);
      tests++;
      if (busy !== 1'b1 || done_cnt !== 0) begin
        fails++;
        $display("[TB] FAIL %s arm_hold: busy=%0b done_cnt=%0d, required busy=1 done_cnt=0", name, busy, done_cnt);
      end
      rx = 1'b1;
    end
    step_n(4);
    send_sync(p, 5);
    wait_result(name, 2000, gd, ge);
    rx = 1'b1;
    tests++;
    if (gd != !exp_err || ge != exp_err) begin
      fails++;
      $display("[TB] FAIL %s outcome: done=%0b error=%0b, required done=%0b error=%0b", name, gd, ge, !exp_err, exp_err);
    end
    tests++;
    if (dvsr !== exp_dvsr || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s result_cycle: dvsr=%0d busy=%0b, required dvsr=%0d busy=0", name, dvsr, busy, exp_dvsr);
    end
    if (gd) begin
      first = -1;
      for (int i = 1; i < int'(exp_dvsr) + 8; i++) begin
        @(negedge clk);
        if (baud_tick) begin
          first = i;
          break;
        end
      end
      gap = -1;
      for (int i = 1; i < int'(exp_dvsr) + 8; i++) begin
        @(negedge clk);
        if (baud_tick) begin
          gap = i;
          break;
        end
      end
      tests++;
      if (first != int'(exp_dvsr) || gap != int'(exp_dvsr) + 1) begin
        fails++;
        $display("[TB] FAIL %s tick_spacing: first=%0d gap=%0d, required first=%0d gap=%0d",
                 name, first, gap, exp_dvsr, int'(exp_dvsr) + 1);
      end
    end
    step_n(20);
    tests++;
    if (done_cnt != (exp_err ? 0 : 1) || error_cnt != (exp_err ? 1 : 0) || overlap_cnt != 0) begin
      fails++;
      $display("[TB] FAIL %s pulse_counts: done=%0d error=%0d overlap=%0d, required done=%0d error=%0d overlap=0",
               name, done_cnt, error_cnt, overlap_cnt, exp_err ? 0 : 1, exp_err ? 1 : 0);
    end
    if (!exp_err) begin
      tests++;
      if (done_tick_ok !== 1'b1 || done_dvsr !== exp_dvsr) begin
        fails++;
        $display("[TB] FAIL %s commit_on_tick: tick_before=%0b dvsr_at_done=%0d, required 1 and %0d",
                 name, done_tick_ok, done_dvsr, exp_dvsr);
      end
    end
  endtask

  task automatic test_reset();
    tests++;
    if (dvsr !== 16'd650 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_values: dvsr=%0d busy=%0b done=%0b error=%0b, required 650/0/0/0", dvsr, busy, done, error);
    end
    reset_n = 1'b1;
    step_n(3);
    tests++;
    if (dvsr !== 16'd650 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("[TB] FAIL after_reset: dvsr=%0d busy=%0b done=%0b error=%0b, required 650/0/0/0", dvsr, busy, done, error);
    end
  endtask

  task automatic test_calibration();
    run_cal("cal_160", 160, 0, 16'd9, 1'b0);
    run_cal("cal_1000", 1000, 0, 16'd62, 1'b0);
    run_cal("cal_1050_round_up", 1050, 0, 16'd65, 1'b0);
  endtask

  task automatic test_arm_wait();
    run_cal("arm_wait", 160, 500, 16'd9, 1'b0);
  endtask

  task automatic test_short_period();
    run_cal("period_7", 7, 0, 16'd9, 1'b1);
    run_cal("period_16_q1", 16, 0, 16'd9, 1'b1);
    run_cal("period_24_q2", 24, 0, 16'd1, 1'b0);
  endtask

  task automatic test_abort();
    done_cnt = 0;
    error_cnt = 0;
    pulse_start();
    step_n(4);
    send_sync(160, 3);
    step_n(4);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL abort_pre: busy=%0b, required 1", busy);
    end
    abort = 1'b1;
    step_n(1);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_idle: busy=%0b, required 0", busy);
    end
    abort = 1'b0;
    rx = 1'b1;
    step_n(2000);
    tests++;
    if (done_cnt != 0 || error_cnt != 0 || dvsr !== 16'd1) begin
      fails++;
      $display("[TB] FAIL abort_quiet: done=%0d error=%0d dvsr=%0d, required 0/0/1", done_cnt, error_cnt, dvsr);
    end
    run_cal("abort_recover", 160, 0, 16'd9, 1'b0);
  endtask

  task automatic test_start_abort();
    done_cnt = 0;
    start = 1'b1;
    abort = 1'b1;
    step_n(1);
    start = 1'b0;
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL start_abort: busy=%0b, required 0", busy);
    end
    step_n(5);
    tests++;
    if (busy !== 1'b0 || done_cnt != 0) begin
      fails++;
      $display("[TB] FAIL start_abort_later: busy=%0b done=%0d, required 0/0", busy, done_cnt);
    end
  endtask

  task automatic test_reset_commit();
    done_cnt = 0;
    tick_en = 1'b0;
    pulse_start();
    step_n(4);
    send_sync(160, 5);
    step_n(6);
    rx = 1'b1;
    tests++;
    if (busy !== 1'b1 || dvsr !== 16'd9) begin
      fails++;
      $display("[TB] FAIL commit_hold: busy=%0b dvsr=%0d, required 1/9", busy, dvsr);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (dvsr !== 16'd650 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_in_commit: dvsr=%0d busy=%0b done=%0b, required 650/0/0", dvsr, busy, done);
    end
    step_n(2);
    reset_n = 1'b1;
    tick_en = 1'b1;
    step_n(1000);
    tests++;
    if (done_cnt != 0 || dvsr !== 16'd650 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_commit_after: done=%0d dvsr=%0d busy=%0b, required 0/650/0", done_cnt, dvsr, busy);
    end
  endtask

  initial begin
    step_n(3);
    test_reset();
    test_calibration();
    test_arm_wait();
    test_short_period();
    test_abort();
    test_start_abort();
    test_reset_commit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
